// File: rtl/rn_release_sequencer_if.sv
// Bundle for the RN release sequencer: soft-reset handshake plus RN/status outputs.
// master = requester / consumer side, slave = the sequencer.
interface rn_release_sequencer_if #(
    parameter int NDOM = 4
);
    logic [NDOM-1:0] SREQ;
    logic [NDOM-1:0] SACK;
    logic [NDOM-1:0] RN;
    logic            BUSY;
    logic            DONE;

    modport master (
        output SREQ,
        input  SACK,
        input  RN,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  SREQ,
        output SACK,
        output RN,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/rn_release_sequencer.sv
// Staged RN release for DFFRNQ banks: hold, release one domain every GAP cycles, then
// optional round-robin soft reset per domain (compiled in with `define RNSEQ_SOFT_EN).
module rn_release_sequencer #(
    parameter int NDOM = 4,
    parameter int HOLD = 2,
    parameter int GAP  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    rn_release_sequencer_if.slave bus
);
    localparam int          MAXC   = (HOLD > GAP) ? HOLD : GAP;
    localparam int          CW     = $clog2(MAXC + 1);
    localparam int          IW     = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam int unsigned NDOM_U = NDOM;
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(GAP - 1);
    localparam logic [IW-1:0] LAST    = IW'(NDOM - 1);

`ifdef RNSEQ_SOFT_EN
    typedef enum logic [1:0] {ASSERT, RELEASE, RUN, SOFT} state_t;
`else
    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
`endif

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [IW-1:0]   idx, idx_d;
    logic [NDOM-1:0] rn, rn_d;
    logic [NDOM-1:0] sack, sack_d;
    logic            busy, busy_d;
    logic            done, done_d;

`ifdef RNSEQ_SOFT_EN
    logic [IW-1:0]   ptr, ptr_d;
    logic [IW-1:0]   gsel, gsel_d;
    logic [NDOM-1:0] elig;
    logic [IW-1:0]   grant;
    logic            grant_vld;

    // The domain acknowledged this cycle is masked so a late-dropping SREQ is not re-granted.
    assign elig = bus.SREQ & ~sack;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < NDOM_U; i++) begin
            int unsigned j;
            j = (32'(ptr) + i) % NDOM_U;
            if (!grant_vld && elig[j]) begin
                grant_vld = 1'b1;
                grant     = IW'(j);
            end
        end
    end
`else
    logic unused_sreq;
    assign unused_sreq = ^bus.SREQ;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ASSERT;
            cnt   <= '0;
            idx   <= '0;
            rn    <= '0;
            sack  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef RNSEQ_SOFT_EN
            ptr   <= '0;
            gsel  <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            rn    <= rn_d;
            sack  <= sack_d;
            busy  <= busy_d;
            done  <= done_d;
`ifdef RNSEQ_SOFT_EN
            ptr   <= ptr_d;
            gsel  <= gsel_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rn_d    = rn;
        sack_d  = '0;
        busy_d  = busy;
        done_d  = done;
`ifdef RNSEQ_SOFT_EN
        ptr_d   = ptr;
        gsel_d  = gsel;
`endif
        unique case (state)
            ASSERT: begin
                if (cnt == HOLD_M1) begin
                    rn_d[0] = 1'b1;
                    cnt_d   = '0;
                    if (NDOM == 1) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IW'(1);
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RELEASE: begin
                // Counter restarts on every release, not just on state change.
                if (cnt == GAP_M1) begin
                    rn_d[idx] = 1'b1;
                    cnt_d     = '0;
                    if (idx == LAST) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RUN: begin
`ifdef RNSEQ_SOFT_EN
                if (grant_vld) begin
                    rn_d[grant] = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    gsel_d      = grant;
                    ptr_d       = (grant == LAST) ? '0 : grant + 1'b1;
                    cnt_d       = '0;
                    state_d     = SOFT;
                end
`endif
            end
`ifdef RNSEQ_SOFT_EN
            SOFT: begin
                if (cnt == HOLD_M1) begin
                    rn_d[gsel]   = 1'b1;
                    sack_d[gsel] = 1'b1;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = RUN;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.RN   = rn;
    assign bus.SACK = sack;
    assign bus.BUSY = busy;
    assign bus.DONE = done;
endmodule
